dmem_trace_fifo: RTL and testbench

//  Captures every core data-memory access (address, data, direction, fetch PC) into a trace FIFO.

---
 rtl/dmem_trace_fifo.sv | 144 ++++++++++++++
 tb/tb_dmem_trace_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_trace_fifo.sv
// Trace FIFO for core data-memory accesses with a first-word-fall-through drain port,
// sticky overflow flag and saturating drop counter. Optional TRACE_TIMESTAMP_EN adds a cycle stamp per record.
module dmem_trace_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int DROP_W     = 16
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          d_req,
   input  logic                          d_rw,
   input  logic [DATA_WIDTH-1:0]         daddr,
   input  logic [DATA_WIDTH-1:0]         ddata_w,
   input  logic [DATA_WIDTH-1:0]         ddata_r,
   input  logic [DATA_WIDTH-1:0]         iaddr,
   input  logic                          clr,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_pc,
   output logic [DATA_WIDTH-1:0]         out_addr,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_rw,
   output logic                          out_misalign,
`ifdef TRACE_TIMESTAMP_EN
   output logic [31:0]                   out_ts,
`endif
   output logic [$clog2(DEPTH):0]        level,
   output logic                          full,
   output logic                          empty,
   output logic                          overflow,
   output logic [DROP_W-1:0]             drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
      logic [31:0]           ts;
`endif
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic                  rw;
   } rec_t;

   rec_t          mem [DEPTH];
   rec_t          wr_rec;
   rec_t          head;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [LW-1:0] level_nxt;
   logic          do_push;
   logic          do_pop;
   logic          do_drop;

   // Handshake: a record leaves the head at an edge where out_valid && out_ready are both high;
   // out_valid never drops and head data never changes until that happens.
   assign out_valid = !empty;
   assign do_pop    = out_valid && out_ready;
   assign do_push   = !RESET && d_req && (!full || do_pop);
   assign do_drop   = !RESET && d_req && full && !do_pop;
   assign level_nxt = level + LW'(do_push) - LW'(do_pop);

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] ts_cnt;

   always_ff @(posedge CLK) begin
      if (RESET) ts_cnt <= '0;
      else       ts_cnt <= ts_cnt + 32'd1;
   end
`endif

   always_comb begin
      wr_rec      = '0;
`ifdef TRACE_TIMESTAMP_EN
      wr_rec.ts   = ts_cnt;
`endif
      wr_rec.pc   = iaddr;
      wr_rec.addr = daddr;
      wr_rec.data = d_rw ? ddata_w : ddata_r;
      wr_rec.rw   = d_rw;
   end

   // Storage carries no reset; the empty mask below keeps stale contents invisible.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= wr_rec;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt;
         full  <= (level_nxt == LW'(DEPTH));
         empty <= (level_nxt == '0);
      end
   end

   // A drop in the same cycle as clr is counted as the first drop after the clear.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (do_drop) begin
         overflow <= 1'b1;
         if (clr)              drop_cnt <= DROP_W'(1);
         else if (~&drop_cnt)  drop_cnt <= drop_cnt + DROP_W'(1);
      end else if (clr) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      out_pc       = '0;
      out_addr     = '0;
      out_data     = '0;
      out_rw       = 1'b0;
      out_misalign = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      out_ts       = '0;
`endif
      if (!empty) begin
         out_pc       = head.pc;
         out_addr     = head.addr;
         out_data     = head.data;
         out_rw       = head.rw;
         out_misalign = (head.addr[1:0] != 2'b00);
`ifdef TRACE_TIMESTAMP_EN
         out_ts       = head.ts;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_trace_fifo.sv
// Bench for dmem_trace_fifo: queue-based reference model checked every cycle plus literal spot checks.
// Define TRACE_TIMESTAMP_EN for both files to exercise the timestamp field.
module tb_dmem_trace_fifo;

   localparam int DW     = 32;
   localparam int DEPTH  = 16;
   localparam int DROP_W = 4;
   localparam int LW     = $clog2(DEPTH) + 1;
   localparam int DMAX   = (1 << DROP_W) - 1;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              d_req, d_rw, clr, out_ready;
   logic [DW-1:0]     daddr, ddata_w, ddata_r, iaddr;
   logic              out_valid, out_rw, out_misalign;
   logic [DW-1:0]     out_pc, out_addr, out_data;
   logic [LW-1:0]     level;
   logic              full, empty, overflow;
   logic [DROP_W-1:0] drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
   logic [31:0]       out_ts;
`endif

   int n_cmp = 0;
   int n_err = 0;

   dmem_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .CLK(CLK), .RESET(RESET), .d_req(d_req), .d_rw(d_rw), .daddr(daddr),
      .ddata_w(ddata_w), .ddata_r(ddata_r), .iaddr(iaddr), .clr(clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_addr(out_addr), .out_data(out_data), .out_rw(out_rw),
      .out_misalign(out_misalign),
`ifdef TRACE_TIMESTAMP_EN
      .out_ts(out_ts),
`endif
      .level(level), .full(full), .empty(empty), .overflow(overflow),
      .drop_cnt(drop_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: an ordered list of accepted records plus overflow bookkeeping.
   typedef struct {
      logic [DW-1:0] pc;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
      logic          rw;
      logic [31:0]   ts;
   } rec_t;

   rec_t        mq[$];
   bit          m_ovf;
   int          m_drop;
   logic [31:0] m_ts;
   bit          live = 1'b0;

   always @(posedge CLK) begin
      bit   pop, push, drop;
      rec_t r;
      if (RESET) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_drop = 0;
         m_ts   = '0;
         live   = 1'b1;
      end else if (live) begin
         pop  = (mq.size() > 0) && out_ready;
         drop = d_req && (mq.size() == DEPTH) && !pop;
         push = d_req && !drop;
         if (pop) void'(mq.pop_front());
         if (push) begin
            r.pc   = iaddr;
            r.addr = daddr;
            r.data = d_rw ? ddata_w : ddata_r;
            r.rw   = d_rw;
            r.ts   = m_ts;
            mq.push_back(r);
         end
         if (drop) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < DMAX) ? m_drop + 1 : DMAX);
         end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
         end
         m_ts = m_ts + 32'd1;
      end
   end

   always @(negedge CLK) begin
      rec_t h;
      if (live) begin
         h = '{pc: '0, addr: '0, data: '0, rw: 1'b0, ts: '0};
         if (mq.size() > 0) h = mq[0];
         check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
         check("level", 64'(level), 64'(mq.size()));
         check("full", 64'(full), 64'(mq.size() == DEPTH));
         check("empty", 64'(empty), 64'(mq.size() == 0));
         check("overflow", 64'(overflow), 64'(m_ovf));
         check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
         check("out_pc", 64'(out_pc), 64'(h.pc));
         check("out_addr", 64'(out_addr), 64'(h.addr));
         check("out_data", 64'(out_data), 64'(h.data));
         check("out_rw", 64'(out_rw), 64'(h.rw));
         check("out_misalign", 64'(out_misalign), 64'((mq.size() != 0) && (h.addr % 4 != 0)));
`ifdef TRACE_TIMESTAMP_EN
         check("out_ts", 64'(out_ts), 64'(h.ts));
`endif
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_rec(input logic rw, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input logic [DW-1:0] pc);
      d_req   = 1'b1;
      d_rw    = rw;
      daddr   = a;
      ddata_w = wd;
      ddata_r = rd;
      iaddr   = pc;
   endtask

   initial begin
      RESET = 1'b1; d_req = 1'b0; d_rw = 1'b0; clr = 1'b0; out_ready = 1'b0;
      daddr = '0; ddata_w = '0; ddata_r = '0; iaddr = '0;
      step(); step();
      RESET = 1'b0;
      check("rst_level", 64'(level), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      check("rst_addr", 64'(out_addr), 64'd0);

      // Single store
      set_rec(1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 32'h40);
      step();
      d_req = 1'b0;
      check("st_valid", 64'(out_valid), 64'd1);
      check("st_addr", 64'(out_addr), 64'h100);
      check("st_data", 64'(out_data), 64'hDEADBEEF);
      check("st_rw", 64'(out_rw), 64'd1);
      check("st_pc", 64'(out_pc), 64'h40);
      check("st_level", 64'(level), 64'd1);
      check("st_misalign", 64'(out_misalign), 64'd0);

      // Misaligned load behind it, then pop the store
      set_rec(1'b0, 32'h102, 32'hFFFF0000, 32'h1234, 32'h44);
      step();
      d_req = 1'b0;
      check("ld_stable_head", 64'(out_addr), 64'h100);
      out_ready = 1'b1;
      step();
      check("ld_rw", 64'(out_rw), 64'd0);
      check("ld_data", 64'(out_data), 64'h1234);
      check("ld_misalign", 64'(out_misalign), 64'd1);
      step();
      out_ready = 1'b0;
      check("ld_empty", 64'(empty), 64'd1);

      // Fill, then three drops
      for (int i = 0; i < DEPTH; i++) begin
         set_rec(1'b1, 32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), 32'h0, 32'h2000 + 32'(4 * i));
         step();
      end
      check("fill_full", 64'(full), 64'd1);
      check("fill_level", 64'(level), 64'd16);
      for (int i = 0; i < 3; i++) begin
         set_rec(1'b1, 32'h3000, 32'hBAD0 + 32'(i), 32'h0, 32'h3000);
         step();
      end
      d_req = 1'b0;
      check("drop_ovf", 64'(overflow), 64'd1);
      check("drop_cnt3", 64'(drop_cnt), 64'd3);

      // Push and pop together while full
      set_rec(1'b1, 32'h4000, 32'hBEEF0, 32'h0, 32'h4004);
      out_ready = 1'b1;
      step();
      d_req = 1'b0;
      check("pp_level", 64'(level), 64'd16);
      check("pp_drop", 64'(drop_cnt), 64'd3);
      check("pp_head", 64'(out_data), 64'hA001);
      for (int i = 0; i < DEPTH - 1; i++) step();
      check("pp_last", 64'(out_data), 64'hBEEF0);
      step();
      out_ready = 1'b0;
      check("drain_empty", 64'(empty), 64'd1);
      check("drain_addr0", 64'(out_addr), 64'd0);
      check("drain_data0", 64'(out_data), 64'd0);

      // Plain clear
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_ovf", 64'(overflow), 64'd0);
      check("clr_drop", 64'(drop_cnt), 64'd0);

      // clr coinciding with a drop, then saturation
      for (int i = 0; i < DEPTH; i++) begin
         set_rec(1'b0, 32'h5000 + 32'(i), 32'h0, 32'hC000 + 32'(i), 32'h6000);
         step();
      end
      set_rec(1'b1, 32'h7000, 32'h7, 32'h0, 32'h7000);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clrdrop_ovf", 64'(overflow), 64'd1);
      check("clrdrop_cnt", 64'(drop_cnt), 64'd1);
      for (int i = 0; i < DEPTH; i++) step();
      d_req = 1'b0;
      check("drop_sat", 64'(drop_cnt), 64'(DMAX));

      // Reset with five entries queued
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_rec(1'b1, 32'h8000 + 32'(4 * i), 32'h8800 + 32'(i), 32'h0, 32'h9000);
         step();
      end
      d_req = 1'b0;
      check("pre_rst_level", 64'(level), 64'd5);
      RESET = 1'b1;
      d_req = 1'b1;
      step();
      RESET = 1'b0;
      d_req = 1'b0;
      check("mid_rst_level", 64'(level), 64'd0);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ovf", 64'(overflow), 64'd0);

      // First push three cycles after reset
      step(); step(); step();
      set_rec(1'b1, 32'hA0, 32'h11, 32'h0, 32'hB0);
      step();
      d_req = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      check("ts_first", 64'(out_ts), 64'd3);
`endif
      check("ts_rec_addr", 64'(out_addr), 64'hA0);

      // Mixed traffic
      for (int i = 0; i < 400; i++) begin
         d_req     = ($urandom_range(0, 3) != 0);
         d_rw      = 1'($urandom_range(0, 1));
         daddr     = $urandom;
         ddata_w   = $urandom;
         ddata_r   = $urandom;
         iaddr     = $urandom;
         out_ready = ($urandom_range(0, 2) == 0);
         clr       = ($urandom_range(0, 31) == 0);
         step();
      end
      d_req = 1'b0;
      clr = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) step();
      check("final_empty", 64'(empty), 64'd1);

      @(negedge CLK);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
